// File: rtl/wb_trace_buffer.sv
// Timestamped trace FIFO for the CPU write-back stream, drained over a valid/ready port.
// Each write that cannot be queued sets a sticky overflow flag and bumps a saturating drop counter.
module wb_trace_buffer #(
   parameter int DEPTH   = 8,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int STAMP_W = 8,
   parameter int DROP_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     wb_we,
   input  logic [ADDR_W-1:0]        wb_reg_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     trace_ready,
   output logic                     trace_valid,
   output logic [ADDR_W-1:0]        trace_reg_addr,
   output logic [DATA_W-1:0]        trace_data,
   output logic [STAMP_W-1:0]       trace_stamp,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_count
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = ADDR_W + DATA_W + STAMP_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [STAMP_W-1:0] stamp;
   logic [CNT_W-1:0]   count_next;
   logic [ENTRY_W-1:0] head;
   logic               push;
   logic               pop;
   logic               drop;

   assign trace_valid = (count != '0);
   assign pop         = trace_valid && trace_ready;
   assign push        = wb_we && (!full || pop);
   assign drop        = wb_we && full && !pop;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // Head fields are forced to zero when empty so stale slots never leak out.
   assign head           = mem[rd_ptr];
   assign trace_reg_addr = trace_valid ? head[ENTRY_W-1 -: ADDR_W] : '0;
   assign trace_data     = trace_valid ? head[STAMP_W +: DATA_W]   : '0;
   assign trace_stamp    = trace_valid ? head[STAMP_W-1:0]         : '0;

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= {wb_reg_addr, wb_data, stamp};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         stamp      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         stamp      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         stamp <= stamp + STAMP_W'(1);
         count <= count_next;
         full  <= (count_next == FULL_CNT);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (!(&drop_count)) begin
               drop_count <= drop_count + DROP_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed and random checks of wb_trace_buffer: latency, ordering, overflow, clear, stamp wrap, reset.
module tb_wb_trace_buffer;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        wb_we;
   logic [3:0]  wb_reg_addr;
   logic [15:0] wb_data;
   logic        trace_ready;
   logic        trace_valid;
   logic [3:0]  trace_reg_addr;
   logic [15:0] trace_data;
   logic [7:0]  trace_stamp;
   logic [3:0]  count;
   logic        full;
   logic        overflow;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;

   wb_trace_buffer #(
      .DEPTH(8), .DATA_W(16), .ADDR_W(4), .STAMP_W(8), .DROP_W(8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear),
      .wb_we          (wb_we),
      .wb_reg_addr    (wb_reg_addr),
      .wb_data        (wb_data),
      .trace_ready    (trace_ready),
      .trace_valid    (trace_valid),
      .trace_reg_addr (trace_reg_addr),
      .trace_data     (trace_data),
      .trace_stamp    (trace_stamp),
      .count          (count),
      .full           (full),
      .overflow       (overflow),
      .drop_count     (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      clear       = 1'b0;
      wb_we       = 1'b0;
      wb_reg_addr = '0;
      wb_data     = '0;
      trace_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push_one(input logic [3:0] a, input logic [15:0] d);
      wb_we       = 1'b1;
      wb_reg_addr = a;
      wb_data     = d;
      tick();
      wb_we = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({trace_valid, trace_reg_addr, trace_data, trace_stamp, count, full, overflow, drop_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b reg=%h data=%h stamp=%h count=%0d full=%b ovf=%b drops=%0d, required all 0",
                  trace_valid, trace_reg_addr, trace_data, trace_stamp, count, full, overflow, drop_count);
      end
   endtask

   task automatic test_single();
      apply_reset();
      repeat (5) tick();
      push_one(4'd3, 16'h00AB);
      checks++;
      if ({trace_valid, trace_reg_addr, trace_data, trace_stamp, count} !== {1'b1, 4'd3, 16'h00AB, 8'd5, 4'd1}) begin
         errors++;
         $display("FAIL single_head valid=%b reg=%h data=%h stamp=%0d count=%0d, required 1 3 00ab 5 1",
                  trace_valid, trace_reg_addr, trace_data, trace_stamp, count);
      end
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      checks++;
      if ({trace_valid, count, trace_data} !== {1'b0, 4'd0, 16'h0}) begin
         errors++;
         $display("FAIL single_drain valid=%b count=%0d data=%h, required 0 0 0000", trace_valid, count, trace_data);
      end
   endtask

   task automatic test_fill_overflow();
      apply_reset();
      for (int i = 0; i < 8; i++) push_one(4'(i), 16'h1000 + 16'(i));
      checks++;
      if ({count, full, overflow} !== {4'd8, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL fill_full count=%0d full=%b ovf=%b, required 8 1 0", count, full, overflow);
      end
      push_one(4'hF, 16'hFFFF);
      checks++;
      if ({count, overflow, drop_count} !== {4'd8, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL fill_drop count=%0d ovf=%b drops=%0d, required 8 1 1", count, overflow, drop_count);
      end
      trace_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({trace_valid, trace_reg_addr, trace_data, trace_stamp} !== {1'b1, 4'(i), 16'h1000 + 16'(i), 8'(i)}) begin
            errors++;
            $display("FAIL fill_order[%0d] valid=%b reg=%h data=%h stamp=%0d, required 1 %h %h %0d",
                     i, trace_valid, trace_reg_addr, trace_data, trace_stamp, i, 16'h1000 + 16'(i), i);
         end
         tick();
      end
      trace_ready = 1'b0;
      checks++;
      if ({trace_valid, count, full} !== {1'b0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL fill_empty valid=%b count=%0d full=%b, required 0 0 0", trace_valid, count, full);
      end
   endtask

   task automatic test_full_push_pop();
      logic [3:0]  ea;
      logic [15:0] ed;
      logic [7:0]  es;
      apply_reset();
      for (int i = 0; i < 8; i++) push_one(4'(i), 16'h2000 + 16'(i));
      trace_ready = 1'b1;
      push_one(4'd9, 16'hBEEF);
      trace_ready = 1'b0;
      checks++;
      if ({count, full, overflow, drop_count} !== {4'd8, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL full_pushpop count=%0d full=%b ovf=%b drops=%0d, required 8 1 0 0",
                  count, full, overflow, drop_count);
      end
      trace_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ea = (k < 7) ? 4'(k + 1) : 4'd9;
         ed = (k < 7) ? 16'h2000 + 16'(k + 1) : 16'hBEEF;
         es = 8'(k + 1);
         checks++;
         if ({trace_reg_addr, trace_data, trace_stamp} !== {ea, ed, es}) begin
            errors++;
            $display("FAIL full_pushpop_order[%0d] reg=%h data=%h stamp=%0d, required %h %h %0d",
                     k, trace_reg_addr, trace_data, trace_stamp, ea, ed, es);
         end
         tick();
      end
      trace_ready = 1'b0;
   endtask

   task automatic test_saturate_clear();
      apply_reset();
      for (int i = 0; i < 8; i++) push_one(4'(i), 16'(i));
      wb_we = 1'b1;
      repeat (300) tick();
      wb_we = 1'b0;
      checks++;
      if ({count, overflow, drop_count} !== {4'd8, 1'b1, 8'hFF}) begin
         errors++;
         $display("FAIL saturate count=%0d ovf=%b drops=%h, required 8 1 ff", count, overflow, drop_count);
      end
      clear = 1'b1;
      wb_we = 1'b1;
      tick();
      clear = 1'b0;
      wb_we = 1'b0;
      checks++;
      if ({trace_valid, count, full, overflow, drop_count} !== {1'b0, 4'd0, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL clear valid=%b count=%0d full=%b ovf=%b drops=%0d, required 0 0 0 0 0",
                  trace_valid, count, full, overflow, drop_count);
      end
      push_one(4'd7, 16'h7777);
      checks++;
      if ({count, trace_stamp, trace_data} !== {4'd1, 8'd0, 16'h7777}) begin
         errors++;
         $display("FAIL clear_stamp count=%0d stamp=%0d data=%h, required 1 0 7777", count, trace_stamp, trace_data);
      end
   endtask

   task automatic test_wrap_async_reset();
      apply_reset();
      repeat (260) tick();
      push_one(4'd1, 16'h0101);
      checks++;
      if ({trace_valid, trace_stamp} !== {1'b1, 8'd4}) begin
         errors++;
         $display("FAIL stamp_wrap valid=%b stamp=%0d, required 1 4", trace_valid, trace_stamp);
      end
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_one(4'(i + 2), 16'h5000 + 16'(i));
      trace_ready = 1'b1;
      @(posedge clk);
      #2;
      checks++;
      if (count !== 4'd4) begin
         errors++;
         $display("FAIL mid_drain_count count=%0d, required 4", count);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({trace_valid, trace_reg_addr, trace_data, trace_stamp, count, full, overflow, drop_count} !== '0) begin
         errors++;
         $display("FAIL async_reset valid=%b reg=%h data=%h stamp=%h count=%0d full=%b ovf=%b drops=%0d, required all 0",
                  trace_valid, trace_reg_addr, trace_data, trace_stamp, count, full, overflow, drop_count);
      end
      tick();
      trace_ready = 1'b0;
      reset       = 1'b0;
      tick();
      checks++;
      if ({trace_valid, count} !== {1'b0, 4'd0}) begin
         errors++;
         $display("FAIL after_reset valid=%b count=%0d, required 0 0", trace_valid, count);
      end
   endtask

   task automatic test_random();
      logic [27:0] q[$];
      logic [7:0]  s;
      logic [7:0]  drops;
      logic        ovf;
      logic        m_full;
      logic        m_pop;
      logic        m_push;
      logic [27:0] exp_head;
      int          bad;
      apply_reset();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      s     = 8'd0;
      drops = 8'd0;
      ovf   = 1'b0;
      bad   = 0;
      for (int c = 0; c < 4000; c++) begin
         wb_we       = ($urandom_range(0, 9) < 6);
         wb_reg_addr = 4'($urandom_range(0, 15));
         wb_data     = 16'($urandom);
         trace_ready = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 5 : 8));
         exp_head    = (q.size() != 0) ? q[0] : 28'd0;
         checks++;
         if ({trace_valid, trace_reg_addr, trace_data, trace_stamp, count, full, overflow, drop_count} !==
             {q.size() != 0, exp_head, 4'(q.size()), q.size() == 8, ovf, drops}) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d] valid=%b reg=%h data=%h stamp=%0d count=%0d full=%b ovf=%b drops=%0d, required %b %h %h %0d %0d %b %b %0d",
                        c, trace_valid, trace_reg_addr, trace_data, trace_stamp, count, full, overflow, drop_count,
                        q.size() != 0, exp_head[27:24], exp_head[23:8], exp_head[7:0], q.size(), q.size() == 8, ovf, drops);
         end
         m_full = (q.size() == 8);
         m_pop  = (q.size() != 0) && trace_ready;
         m_push = wb_we && (!m_full || m_pop);
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back({wb_reg_addr, wb_data, s});
         if (wb_we && m_full && !m_pop) begin
            ovf = 1'b1;
            if (drops != 8'hFF) drops = drops + 8'd1;
         end
         s = s + 8'd1;
         tick();
      end
      wb_we       = 1'b0;
      trace_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_push_pop();
      test_saturate_clear();
      test_wrap_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
